mef_tx: RTL

Serial bit-stream transmitter that drives the single-bit E input of the team's sequence-detecting state machines. It accepts a parallel word plus a bit count over a valid/ready handshake and shifts the bits out MSB-first on E, one bit per clock. It then holds E at the idle level for a programmable gap. It sits between a test/control sequencer and any E-consuming FSM, and also serves as the stimulus source in system benches.

---
 rtl/mef_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mef_tx.sv
// Serial bit-stream transmitter: shifts the low LEN bits of a word out MSB-first
// on E, one bit per clock, then holds E idle for GAP cycles before taking the next frame.
module mef_tx #(
  parameter int   DW       = 8,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [DW-1:0] D,
  input  logic [4:0]    LEN,
  input  logic          VALID,
  output logic          READY,
  output logic          E,
  output logic          BUSY,
  output logic          DONE,
  output logic [7:0]    FRAMES
);

  // Handshake: a frame is accepted at a rising edge where VALID && READY and CLR=1;
  // D and LEN are sampled only then. VALID while READY=0 is dropped, never queued.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] sr, sr_nxt;
  logic [4:0]    cnt, cnt_nxt;
  logic [3:0]    gcnt, gcnt_nxt;
  logic          e_nxt, ready_nxt, busy_nxt, done_nxt;
  logic [7:0]    frames_nxt;
  logic          load;
  logic [4:0]    eff_len;
  logic [DW-1:0] aligned;

  always_comb begin
    eff_len = (LEN == 5'd0 || LEN > 5'(DW)) ? 5'(DW) : LEN;
    aligned = D << (5'(DW) - eff_len);
  end

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    gcnt_nxt   = gcnt;
    e_nxt      = E;
    ready_nxt  = READY;
    busy_nxt   = BUSY;
    done_nxt   = 1'b0;
    frames_nxt = FRAMES;
    load       = 1'b0;
    case (state)
      S_IDLE: load = VALID && READY;
      S_SEND: begin
        if (cnt <= 5'd1) begin
          frames_nxt = FRAMES + 8'd1;
          load       = VALID && READY;
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gcnt_nxt  = 4'(GAP);
            e_nxt     = IDLE_LVL;
            ready_nxt = 1'b0;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            e_nxt     = IDLE_LVL;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end
        end else begin
          e_nxt     = sr[DW-1];
          sr_nxt    = sr << 1;
          cnt_nxt   = cnt - 5'd1;
          done_nxt  = (cnt == 5'd2);
          // With no gap, READY opens during the last bit so frames chain back-to-back.
          ready_nxt = (cnt == 5'd2) && (GAP == 0);
        end
      end
      S_GAP: begin
        if (gcnt <= 4'd1) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          gcnt_nxt = gcnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // E is registered, so the first bit goes straight onto E and the rest stay in sr.
    if (load) begin
      state_nxt = S_SEND;
      e_nxt     = aligned[DW-1];
      sr_nxt    = aligned << 1;
      cnt_nxt   = eff_len;
      busy_nxt  = 1'b1;
      done_nxt  = (eff_len == 5'd1);
      ready_nxt = (eff_len == 5'd1) && (GAP == 0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state  <= S_IDLE;
      sr     <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      E      <= IDLE_LVL;
      READY  <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      FRAMES <= 8'd0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      gcnt   <= gcnt_nxt;
      E      <= e_nxt;
      READY  <= ready_nxt;
      BUSY   <= busy_nxt;
      DONE   <= done_nxt;
      FRAMES <= frames_nxt;
    end
  end

endmodule
